// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with dual write, sweep clear engine, optional bypass (REGFILE_MP_BYPASS_EN)
module regfile_mp #(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int NRD   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NRD*AW-1:0] RA,
    output logic [NRD*DW-1:0] RD,
    input  logic [AW-1:0]     WA0,
    input  logic [DW-1:0]     WD0,
    input  logic              WE0,
    input  logic [AW-1:0]     WA1,
    input  logic [DW-1:0]     WD1,
    input  logic              WE1,
    input  logic              CLR,
    output logic              BUSY
);

    // One extra bit so DEPTH == 2**AW is still representable.
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic [DW-1:0] mem [DEPTH];
    state_t        state;
    logic [AW-1:0] ptr;
    logic          busy_q;
    logic          wr0;
    logic          wr1;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    assign wr0  = WE0 && in_range(WA0);
    assign wr1  = WE1 && in_range(WA1);
    assign BUSY = busy_q;

    // Storage, write ports and clear-sweep FSM; port 1 is written last so it wins on address collisions.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr0) begin
                        mem[WA0] <= WD0;
                    end
                    if (wr1) begin
                        mem[WA1] <= WD1;
                    end
                    if (CLR) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Writes are dropped here; upstream is expected to stall on BUSY.
                    mem[ptr] <= '0;
                    if (ptr == LAST) begin
                        state  <= IDLE;
                        ptr    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ptr    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Asynchronous read ports; out-of-range addresses read zero.
    always_comb begin
        RD = '0;
        for (int i = 0; i < NRD; i++) begin
            if (in_range(RA[i*AW +: AW])) begin
                RD[i*DW +: DW] = mem[RA[i*AW +: AW]];
            end
`ifdef REGFILE_MP_BYPASS_EN
            // Forward same-cycle write data; port 1 overrides port 0, never during a sweep.
            if (state == IDLE) begin
                if (wr0 && (WA0 == RA[i*AW +: AW])) begin
                    RD[i*DW +: DW] = WD0;
                end
                if (wr1 && (WA1 == RA[i*AW +: AW])) begin
                    RD[i*DW +: DW] = WD1;
                end
            end
`endif
        end
    end

endmodule
